// File: rtl/alu_share_arbiter_pkg.sv
// Shared constants for the ALU share arbiter: ALU op codes, legal-op bound and FSM encodings.
package alu_share_arbiter_pkg;

   localparam logic [3:0] ALU_ADD    = 4'b0000;
   localparam logic [3:0] ALU_SUB    = 4'b0001;
   localparam logic [3:0] ALU_AND    = 4'b0010;
   localparam logic [3:0] ALU_OR     = 4'b0011;
   localparam logic [3:0] ALU_XOR    = 4'b0100;
   localparam logic [3:0] ALU_SLT    = 4'b0101;
   localparam logic [3:0] ALU_SLTU   = 4'b0110;
   localparam logic [3:0] ALU_LUI_A  = 4'b0111;
   localparam logic [3:0] ALU_AUIPC  = 4'b1000;
   localparam logic [3:0] ALU_LUI    = 4'b1001;
   localparam logic [3:0] ALU_SLL    = 4'b1010;
   localparam logic [3:0] ALU_SRA    = 4'b1011;
   localparam logic [3:0] ALU_SRL    = 4'b1100;
   localparam logic [3:0] ALU_OP_MAX = 4'b1100;

   typedef logic [1:0] state_t;

   localparam state_t IDLE = 2'd0;
   localparam state_t EXEC = 2'd1;
   localparam state_t RESP = 2'd2;

endpackage

// File: rtl/alu_share_arbiter_rr_arbiter2.sv
// Stateless two-way round-robin grant: the pointer (held by the parent) breaks ties.
module alu_share_arbiter_rr_arbiter2
   import alu_share_arbiter_pkg::*;
(
   input  logic       valid0,
   input  logic       valid1,
   input  logic       ptr,
   input  logic       en,
   output logic [1:0] grant
);

   always_comb begin
      grant = 2'b00;
      if (en) begin
         if (valid0 && valid1) begin
            grant = ptr ? 2'b10 : 2'b01;
         end else begin
            grant = {valid1, valid0};
         end
      end
   end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one external ALU between two requesters: round-robin accept, one-cycle execute,
// registered response with backpressure.
module alu_share_arbiter
   import alu_share_arbiter_pkg::*;
#(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned OP_W   = 4,
   parameter int unsigned CNT_W  = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req0_valid,
   output logic              req0_ready,
   input  logic [DATA_W-1:0] req0_a,
   input  logic [DATA_W-1:0] req0_b,
   input  logic [OP_W-1:0]   req0_op,
   output logic              rsp0_valid,
   input  logic              rsp0_ready,
   output logic [DATA_W-1:0] rsp0_result,
   output logic              rsp0_zero,
   output logic              rsp0_err,
   input  logic              req1_valid,
   output logic              req1_ready,
   input  logic [DATA_W-1:0] req1_a,
   input  logic [DATA_W-1:0] req1_b,
   input  logic [OP_W-1:0]   req1_op,
   output logic              rsp1_valid,
   input  logic              rsp1_ready,
   output logic [DATA_W-1:0] rsp1_result,
   output logic              rsp1_zero,
   output logic              rsp1_err,
   output logic [DATA_W-1:0] alu_a,
   output logic [DATA_W-1:0] alu_b,
   output logic [OP_W-1:0]   alu_ctrl,
   input  logic [DATA_W-1:0] alu_result,
   input  logic              alu_zero,
   output logic              busy,
   output logic [CNT_W-1:0]  op_count
);

   state_t            state_q, state_d;
   logic              ptr_q;
   logic              gnt_q;
   logic [1:0]        win;
   logic [DATA_W-1:0] a_q, b_q, result_q;
   logic [OP_W-1:0]   op_q;
   logic              zero_q, err_q;
   logic [CNT_W-1:0]  count_q;
   logic              accept, rsp_fire, op_legal;

   alu_share_arbiter_rr_arbiter2 u_arb (
      .valid0 (req0_valid),
      .valid1 (req1_valid),
      .ptr    (ptr_q),
      .en     (state_q == IDLE),
      .grant  (win)
   );

   assign accept     = |win;
   assign req0_ready = win[0];
   assign req1_ready = win[1];

   assign rsp0_valid = (state_q == RESP) && !gnt_q;
   assign rsp1_valid = (state_q == RESP) && gnt_q;
   assign rsp_fire   = gnt_q ? (rsp1_valid && rsp1_ready) : (rsp0_valid && rsp0_ready);
   assign op_legal   = (op_q <= OP_W'(ALU_OP_MAX));

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (accept) state_d = EXEC;
         EXEC:    state_d = RESP;
         RESP:    if (rsp_fire) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         ptr_q    <= 1'b0;
         gnt_q    <= 1'b0;
         a_q      <= '0;
         b_q      <= '0;
         op_q     <= '0;
         result_q <= '0;
         zero_q   <= 1'b0;
         err_q    <= 1'b0;
         count_q  <= '0;
      end else begin
         state_q <= state_d;
         if ((state_q == IDLE) && accept) begin
            gnt_q <= win[1];
            a_q   <= win[1] ? req1_a  : req0_a;
            b_q   <= win[1] ? req1_b  : req0_b;
            op_q  <= win[1] ? req1_op : req0_op;
         end
         if (state_q == EXEC) begin
            // Illegal ops never reach the requester as ALU data, only as an error.
            if (op_legal) begin
               result_q <= alu_result;
               zero_q   <= alu_zero;
               err_q    <= 1'b0;
               count_q  <= count_q + CNT_W'(1);
            end else begin
               result_q <= '0;
               zero_q   <= 1'b0;
               err_q    <= 1'b1;
            end
         end
         if (rsp_fire) begin
            ptr_q <= ~gnt_q;
         end
      end
   end

   assign alu_a       = a_q;
   assign alu_b       = b_q;
   assign alu_ctrl    = op_q;
   assign rsp0_result = result_q;
   assign rsp0_zero   = zero_q;
   assign rsp0_err    = err_q;
   assign rsp1_result = result_q;
   assign rsp1_zero   = zero_q;
   assign rsp1_err    = err_q;
   assign busy        = (state_q != IDLE);
   assign op_count    = count_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed scenarios plus a randomized run against a transaction-level model of the arbiter.
module tb_alu_share_arbiter;
   import alu_share_arbiter_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        req0_valid, req0_ready, rsp0_valid, rsp0_ready, rsp0_zero, rsp0_err;
   logic [31:0] req0_a, req0_b, rsp0_result;
   logic [3:0]  req0_op;
   logic        req1_valid, req1_ready, rsp1_valid, rsp1_ready, rsp1_zero, rsp1_err;
   logic [31:0] req1_a, req1_b, rsp1_result;
   logic [3:0]  req1_op;
   logic [31:0] alu_a, alu_b, alu_result;
   logic [3:0]  alu_ctrl;
   logic        alu_zero, busy;
   logic [15:0] op_count;

   int tests_run = 0;
   int tests_failed = 0;
   int exp_cnt = 0;

   always #5 clk = ~clk;

   alu_share_arbiter dut (
      .clk (clk), .reset (reset),
      .req0_valid (req0_valid), .req0_ready (req0_ready), .req0_a (req0_a),
      .req0_b (req0_b), .req0_op (req0_op), .rsp0_valid (rsp0_valid),
      .rsp0_ready (rsp0_ready), .rsp0_result (rsp0_result), .rsp0_zero (rsp0_zero),
      .rsp0_err (rsp0_err),
      .req1_valid (req1_valid), .req1_ready (req1_ready), .req1_a (req1_a),
      .req1_b (req1_b), .req1_op (req1_op), .rsp1_valid (rsp1_valid),
      .rsp1_ready (rsp1_ready), .rsp1_result (rsp1_result), .rsp1_zero (rsp1_zero),
      .rsp1_err (rsp1_err),
      .alu_a (alu_a), .alu_b (alu_b), .alu_ctrl (alu_ctrl), .alu_result (alu_result),
      .alu_zero (alu_zero), .busy (busy), .op_count (op_count)
   );

   // Behavioural ALU; illegal codes return junk the arbiter must not forward.
   function automatic logic [31:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                          input logic [3:0] op);
      case (op)
         4'd0:    return a + b;
         4'd1:    return a - b;
         4'd2:    return a & b;
         4'd3:    return a | b;
         4'd4:    return a ^ b;
         4'd5:    return {31'b0, $signed(a) < $signed(b)};
         4'd6:    return {31'b0, a < b};
         4'd7:    return a;
         4'd8:    return a + b;
         4'd9:    return b;
         4'd10:   return a << b[4:0];
         4'd11:   return $unsigned($signed(a) >>> b[4:0]);
         4'd12:   return a >> b[4:0];
         default: return 32'hDEAD_BEEF;
      endcase
   endfunction

   always_comb begin
      alu_result = alu_fn(alu_a, alu_b, alu_ctrl);
      alu_zero   = (alu_result == 32'd0);
   end

   task automatic clear_inputs();
      req0_valid = 0; req0_a = 0; req0_b = 0; req0_op = 0; rsp0_ready = 0;
      req1_valid = 0; req1_a = 0; req1_b = 0; req1_op = 0; rsp1_ready = 0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1;
      clear_inputs();
      repeat (2) @(negedge clk);
      reset = 0;
      exp_cnt = 0;
   endtask

   task automatic test_reset();
      do_reset();
      #1;
      tests_run++;
      if ({busy, req0_ready, req1_ready, rsp0_valid, rsp1_valid} !== 5'b0) begin
         tests_failed++;
         $display("FAIL reset_ctrl: got busy/rdy0/rdy1/v0/v1=%b want 00000",
                  {busy, req0_ready, req1_ready, rsp0_valid, rsp1_valid});
      end
      tests_run++;
      if (alu_a !== 0 || alu_b !== 0 || alu_ctrl !== 4'b0000 || op_count !== 0) begin
         tests_failed++;
         $display("FAIL reset_regs: got a=%h b=%h ctrl=%b cnt=%0d want 0 0 0000 0",
                  alu_a, alu_b, alu_ctrl, op_count);
      end
      tests_run++;
      if (rsp0_result !== 0 || rsp0_zero !== 0 || rsp0_err !== 0) begin
         tests_failed++;
         $display("FAIL reset_rsp: got res=%h z=%b e=%b want 0 0 0",
                  rsp0_result, rsp0_zero, rsp0_err);
      end
   endtask

   task automatic test_contention();
      do_reset();
      @(negedge clk);
      req0_valid = 1; req0_a = 10; req0_b = 10; req0_op = ALU_SUB;
      req1_valid = 1; req1_a = 32'h0F0; req1_b = 32'h00F; req1_op = ALU_OR;
      #1;
      tests_run++;
      if (req0_ready !== 1 || req1_ready !== 0) begin
         tests_failed++;
         $display("FAIL contend_first: got rdy0=%b rdy1=%b want 1 0", req0_ready, req1_ready);
      end
      @(negedge clk); req0_valid = 0;
      @(negedge clk); #1;
      tests_run++;
      if (rsp0_valid !== 1 || rsp0_result !== 0 || rsp0_zero !== 1 || req1_ready !== 0) begin
         tests_failed++;
         $display("FAIL contend_rsp0: got v=%b res=%h z=%b rdy1=%b want 1 0 1 0",
                  rsp0_valid, rsp0_result, rsp0_zero, req1_ready);
      end
      rsp0_ready = 1;
      @(negedge clk); rsp0_ready = 0; #1;
      tests_run++;
      if (req1_ready !== 1) begin
         tests_failed++;
         $display("FAIL contend_second: got rdy1=%b want 1", req1_ready);
      end
      @(negedge clk); req1_valid = 0;
      @(negedge clk); #1;
      tests_run++;
      if (rsp1_valid !== 1 || rsp1_result !== 32'hFF || rsp1_zero !== 0 || rsp0_valid !== 0) begin
         tests_failed++;
         $display("FAIL contend_rsp1: got v1=%b res=%h z=%b v0=%b want 1 ff 0 0",
                  rsp1_valid, rsp1_result, rsp1_zero, rsp0_valid);
      end
      rsp1_ready = 1;
      exp_cnt += 2;
      @(negedge clk); rsp1_ready = 0;
      // Pointer should be back on requester 0; withdraw before the edge so nothing is accepted.
      req0_valid = 1; req1_valid = 1; #1;
      tests_run++;
      if (req0_ready !== 1 || req1_ready !== 0 || busy !== 0) begin
         tests_failed++;
         $display("FAIL contend_ptr: got rdy0=%b rdy1=%b busy=%b want 1 0 0",
                  req0_ready, req1_ready, busy);
      end
      req0_valid = 0; req1_valid = 0;
   endtask

   task automatic test_single_add();
      @(negedge clk);
      req0_valid = 1; req0_a = 5; req0_b = 7; req0_op = ALU_ADD; #1;
      tests_run++;
      if (req0_ready !== 1) begin
         tests_failed++;
         $display("FAIL add_ready: got %b want 1", req0_ready);
      end
      @(negedge clk); req0_valid = 0; #1;
      tests_run++;
      if (busy !== 1 || rsp0_valid !== 0 || alu_a !== 5 || alu_b !== 7 || alu_ctrl !== ALU_ADD) begin
         tests_failed++;
         $display("FAIL add_exec: got busy=%b v=%b a=%0d b=%0d ctrl=%b want 1 0 5 7 0000",
                  busy, rsp0_valid, alu_a, alu_b, alu_ctrl);
      end
      exp_cnt++;
      @(negedge clk); #1;
      tests_run++;
      if (rsp0_valid !== 1 || rsp0_result !== 12 || rsp0_zero !== 0 || rsp0_err !== 0 ||
          op_count !== 16'(exp_cnt)) begin
         tests_failed++;
         $display("FAIL add_rsp: got v=%b res=%0d z=%b e=%b cnt=%0d want 1 12 0 0 %0d",
                  rsp0_valid, rsp0_result, rsp0_zero, rsp0_err, op_count, exp_cnt);
      end
      rsp0_ready = 1;
      @(negedge clk); rsp0_ready = 0; #1;
      tests_run++;
      if (busy !== 0 || rsp0_valid !== 0) begin
         tests_failed++;
         $display("FAIL add_done: got busy=%b v=%b want 0 0", busy, rsp0_valid);
      end
   endtask

   task automatic test_backpressure();
      @(negedge clk);
      req0_valid = 1; req0_a = 32'h1234; req0_b = 32'h1234; req0_op = ALU_XOR;
      @(negedge clk);
      req0_valid = 0;
      req1_valid = 1; req1_a = 3; req1_b = 4; req1_op = ALU_AND;
      exp_cnt++;
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         #1;
         tests_run++;
         if (rsp0_valid !== 1 || rsp0_result !== 0 || rsp0_zero !== 1 || req1_ready !== 0 ||
             busy !== 1) begin
            tests_failed++;
            $display("FAIL bp_hold%0d: got v=%b res=%h z=%b rdy1=%b busy=%b want 1 0 1 0 1",
                     i, rsp0_valid, rsp0_result, rsp0_zero, req1_ready, busy);
         end
         if (i == 3) rsp0_ready = 1;
         @(negedge clk);
      end
      rsp0_ready = 0; #1;
      tests_run++;
      if (req1_ready !== 1) begin
         tests_failed++;
         $display("FAIL bp_next: got rdy1=%b want 1", req1_ready);
      end
      @(negedge clk); req1_valid = 0;
      exp_cnt++;
      @(negedge clk); #1;
      tests_run++;
      if (rsp1_valid !== 1 || rsp1_result !== 0 || rsp1_zero !== 1) begin
         tests_failed++;
         $display("FAIL bp_rsp1: got v=%b res=%h z=%b want 1 0 1",
                  rsp1_valid, rsp1_result, rsp1_zero);
      end
      rsp1_ready = 1;
      @(negedge clk); rsp1_ready = 0;
   endtask

   task automatic test_illegal();
      @(negedge clk);
      req1_valid = 1; req1_a = 32'h55; req1_b = 32'h66; req1_op = 4'b1111;
      @(negedge clk); req1_valid = 0;
      @(negedge clk); #1;
      tests_run++;
      if (rsp1_valid !== 1 || rsp1_err !== 1 || rsp1_result !== 0 || rsp1_zero !== 0 ||
          op_count !== 16'(exp_cnt)) begin
         tests_failed++;
         $display("FAIL illegal: got v=%b e=%b res=%h z=%b cnt=%0d want 1 1 0 0 %0d",
                  rsp1_valid, rsp1_err, rsp1_result, rsp1_zero, op_count, exp_cnt);
      end
      rsp1_ready = 1;
      @(negedge clk); rsp1_ready = 0;
   endtask

   task automatic test_sra();
      @(negedge clk);
      req0_valid = 1; req0_a = 32'h8000_0000; req0_b = 4; req0_op = ALU_SRA;
      @(negedge clk); req0_valid = 0; #1;
      tests_run++;
      if (alu_ctrl !== 4'b1011) begin
         tests_failed++;
         $display("FAIL sra_ctrl: got %b want 1011", alu_ctrl);
      end
      exp_cnt++;
      @(negedge clk); #1;
      tests_run++;
      if (rsp0_valid !== 1 || rsp0_result !== 32'hF800_0000 || rsp0_err !== 0) begin
         tests_failed++;
         $display("FAIL sra_rsp: got v=%b res=%h e=%b want 1 f8000000 0",
                  rsp0_valid, rsp0_result, rsp0_err);
      end
      rsp0_ready = 1;
      @(negedge clk); rsp0_ready = 0;
   endtask

   // Pointer is on requester 1 here (last served was requester 0).
   task automatic test_reset_mid();
      @(negedge clk);
      req1_valid = 1; req1_a = 9; req1_b = 1; req1_op = ALU_ADD;
      @(negedge clk); req1_valid = 0; reset = 1; #1;
      tests_run++;
      if (busy !== 0 || rsp1_valid !== 0 || op_count !== 0) begin
         tests_failed++;
         $display("FAIL rst_mid_async: got busy=%b v1=%b cnt=%0d want 0 0 0",
                  busy, rsp1_valid, op_count);
      end
      @(negedge clk); reset = 0; exp_cnt = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk); #1;
         tests_run++;
         if (rsp1_valid !== 0 || busy !== 0 || op_count !== 0) begin
            tests_failed++;
            $display("FAIL rst_mid_quiet%0d: got v1=%b busy=%b cnt=%0d want 0 0 0",
                     i, rsp1_valid, busy, op_count);
         end
      end
      @(negedge clk);
      req0_valid = 1; req1_valid = 1; #1;
      tests_run++;
      if (req0_ready !== 1 || req1_ready !== 0) begin
         tests_failed++;
         $display("FAIL rst_mid_ptr: got rdy0=%b rdy1=%b want 1 0", req0_ready, req1_ready);
      end
      req0_valid = 0; req1_valid = 0;
   endtask

   // Transaction-level model: one op outstanding, answered two cycles after acceptance,
   // ties broken in favour of whoever was not served last.
   task automatic test_random();
      bit          pv[2];
      logic [31:0] pa[2], pb[2];
      logic [3:0]  pop[2];
      bit          m_busy = 0;
      int          m_owner = 0, m_age = 0, m_fav = 0, m_cnt = 0, win;
      logic [31:0] e_res;
      bit          e_zero, e_err, r_rdy[2], rv[2], okr;
      do_reset();
      for (int cyc = 0; cyc < 420; cyc++) begin
         @(negedge clk);
         for (int n = 0; n < 2; n++) begin
            if (!pv[n] && cyc < 380 && $urandom_range(0, 2) == 0) begin
               pv[n] = 1;
               pa[n] = $urandom;
               pb[n] = ($urandom_range(0, 3) == 0) ? pa[n] : $urandom;
               pop[n] = 4'($urandom_range(0, 15));
            end
            r_rdy[n] = (cyc >= 380) || ($urandom_range(0, 1) == 1);
         end
         req0_valid = pv[0]; req0_a = pa[0]; req0_b = pb[0]; req0_op = pop[0];
         req1_valid = pv[1]; req1_a = pa[1]; req1_b = pb[1]; req1_op = pop[1];
         rsp0_ready = r_rdy[0]; rsp1_ready = r_rdy[1];
         #1;
         win = -1;
         if (!m_busy) begin
            if (pv[0] && pv[1]) win = m_fav;
            else if (pv[0]) win = 0;
            else if (pv[1]) win = 1;
         end
         tests_run++;
         if (req0_ready !== (win == 0) || req1_ready !== (win == 1)) begin
            tests_failed++;
            $display("FAIL rnd_ready c%0d: got %b%b want %b%b", cyc, req0_ready, req1_ready,
                     win == 0, win == 1);
         end
         rv[0] = m_busy && m_age >= 2 && m_owner == 0;
         rv[1] = m_busy && m_age >= 2 && m_owner == 1;
         okr = (rsp0_valid === rv[0]) && (rsp1_valid === rv[1]) && (busy === m_busy) &&
               (op_count === 16'(m_cnt));
         if (rv[0]) okr = okr && rsp0_result === e_res && rsp0_zero === e_zero &&
                          rsp0_err === e_err;
         if (rv[1]) okr = okr && rsp1_result === e_res && rsp1_zero === e_zero &&
                          rsp1_err === e_err;
         tests_run++;
         if (!okr) begin
            tests_failed++;
            $display("FAIL rnd_rsp c%0d: got v=%b%b busy=%b cnt=%0d res=%h/%h z=%b%b e=%b%b want v=%b%b busy=%b cnt=%0d res=%h z=%b e=%b",
                     cyc, rsp0_valid, rsp1_valid, busy, op_count, rsp0_result, rsp1_result,
                     rsp0_zero, rsp1_zero, rsp0_err, rsp1_err, rv[0], rv[1], m_busy, m_cnt,
                     e_res, e_zero, e_err);
         end
         if (win >= 0) begin
            m_busy = 1; m_owner = win; m_age = 1; pv[win] = 0;
            e_err  = (pop[win] > 4'd12);
            e_res  = e_err ? 32'd0 : alu_fn(pa[win], pb[win], pop[win]);
            e_zero = !e_err && (e_res == 32'd0);
         end else if (m_busy) begin
            if (m_age == 1) begin
               m_age = 2;
               if (!e_err) m_cnt++;
            end else if (r_rdy[m_owner]) begin
               m_busy = 0;
               m_fav = 1 - m_owner;
            end
         end
      end
      clear_inputs();
   endtask

   initial begin
      reset = 1;
      clear_inputs();
      test_reset();
      test_contention();
      test_single_add();
      test_backpressure();
      test_illegal();
      test_sra();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
